// File: rtl/x4xx_versioning_regs_ext_if.sv
// CtrlPort request/response bundle for the versioning register block.
interface x4xx_versioning_regs_ext_if;
    logic        req_wr;
    logic        req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic        resp_ack;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;

    modport master (
        output req_wr, req_rd, req_addr, req_data,
        input  resp_ack, resp_status, resp_data
    );

    modport slave (
        input  req_wr, req_rd, req_addr, req_data,
        output resp_ack, resp_status, resp_data
    );
endinterface

// File: rtl/x4xx_versioning_regs_ext.sv
// Version-info register block: RO version words per component, a STATUS /
// CHECKSUM / ERROR_COUNT trio after them, a fixed-latency response pipeline
// and a background scanner that sums every version word.
module x4xx_versioning_regs_ext #(
    parameter int REG_BASE       = 0,
    parameter int NUM_COMPONENTS = 64,
    parameter int VERSION_WORDS  = 3,
    parameter int READ_LATENCY   = 1
) (
    input  logic                                      s_ctrlport_clk,
    input  logic                                      s_ctrlport_rst_n,
    x4xx_versioning_regs_ext_if.slave                 s_ctrlport,
    input  logic [NUM_COMPONENTS*VERSION_WORDS*32-1:0] version_info,
    output logic                                      checksum_valid
);
    localparam int SB     = NUM_COMPONENTS * 16;
    localparam int TOTAL  = NUM_COMPONENTS * VERSION_WORDS;
    localparam int IW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int WSLOTS = 1 << IW;

    localparam logic [1:0] ST_OKAY   = 2'b00;
    localparam logic [1:0] ST_CMDERR = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    typedef struct packed {
        logic        vld;
        logic [1:0]  sts;
        logic [31:0] dat;
    } resp_t;

    // Flat word table, padded to a power of two so every index is legal.
    logic [31:0] w_words [WSLOTS];
    for (genvar g = 0; g < WSLOTS; g++) begin : g_words
        if (g < TOTAL) begin : g_real
            assign w_words[g] = version_info[g*32 +: 32];
        end else begin : g_pad
            assign w_words[g] = '0;
        end
    end

    state_t      r_state;
    logic [IW-1:0] r_idx;
    logic [31:0] r_sum;
    logic        r_valid;
    logic [15:0] r_err_cnt;
    logic        r_ack;
    logic [1:0]  r_sts;
    logic [31:0] r_dat;

    logic [31:0]   w_addr;
    logic [31:0]   w_off;
    logic          w_in_range;
    logic          w_is_ver;
    logic [1:0]    w_word;
    logic [IW-1:0] w_vidx;
    logic          w_restart;
    logic          w_clear;
    resp_t         w_dec;
    resp_t         w_fin;
    logic          w_unused_bits;

    assign w_addr     = {12'd0, s_ctrlport.req_addr};
    assign w_off      = w_addr - 32'(REG_BASE);
    assign w_in_range = (w_addr >= 32'(REG_BASE)) && (w_addr < 32'(REG_BASE + SB + 16));
    assign w_is_ver   = w_off[31:4] < 28'(NUM_COMPONENTS);
    assign w_word     = w_off[3:2];
    assign w_vidx     = IW'(int'(w_off[31:4]) * VERSION_WORDS + int'(w_word));

    assign w_unused_bits = &{1'b0, s_ctrlport.req_data[31:1], w_off[1:0]};

    // Decode the request into its response and its side effects.
    always_comb begin
        w_dec     = '0;
        w_restart = 1'b0;
        w_clear   = 1'b0;
        if ((s_ctrlport.req_wr || s_ctrlport.req_rd) && w_in_range) begin
            w_dec.vld = 1'b1;
            if (w_is_ver) begin
                if (!s_ctrlport.req_wr && (int'(w_word) < VERSION_WORDS))
                    w_dec.dat = w_words[w_vidx];
                else
                    w_dec.sts = ST_CMDERR;
            end else begin
                case (w_word)
                    2'd0: begin
                        if (s_ctrlport.req_wr) w_restart = s_ctrlport.req_data[0];
                        else w_dec.dat = {r_valid, 24'd0, 7'(NUM_COMPONENTS)};
                    end
                    2'd1: begin
                        if (s_ctrlport.req_wr) w_dec.sts = ST_CMDERR;
                        else w_dec.dat = r_sum;
                    end
                    2'd2: begin
                        if (s_ctrlport.req_wr) w_clear = 1'b1;
                        else w_dec.dat = {16'd0, r_err_cnt};
                    end
                    default: w_dec.sts = ST_CMDERR;
                endcase
            end
        end
    end

    // Extra latency stages; the output register below supplies the last one.
    if (READ_LATENCY > 1) begin : g_pipe
        resp_t r_pipe [READ_LATENCY-1];

        // Shift decoded responses toward the output register.
        always_ff @(posedge s_ctrlport_clk or negedge s_ctrlport_rst_n) begin
            if (!s_ctrlport_rst_n) begin
                for (int i = 0; i < READ_LATENCY-1; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= w_dec;
                for (int i = 1; i < READ_LATENCY-1; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign w_fin = r_pipe[READ_LATENCY-2];
    end else begin : g_nopipe
        assign w_fin = w_dec;
    end

    // Output register: ack pulses, status/data hold between acks.
    always_ff @(posedge s_ctrlport_clk or negedge s_ctrlport_rst_n) begin
        if (!s_ctrlport_rst_n) begin
            r_ack <= 1'b0;
            r_sts <= ST_OKAY;
            r_dat <= '0;
        end else begin
            r_ack <= w_fin.vld;
            if (w_fin.vld) begin
                r_sts <= w_fin.sts;
                r_dat <= w_fin.dat;
            end
        end
    end

    // Error counter bumps as a CMDERR ack is launched; a clear wins a tie.
    always_ff @(posedge s_ctrlport_clk or negedge s_ctrlport_rst_n) begin
        if (!s_ctrlport_rst_n)
            r_err_cnt <= '0;
        else if (w_clear)
            r_err_cnt <= '0;
        else if (w_fin.vld && (w_fin.sts == ST_CMDERR) && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    // Checksum scanner: one word per cycle, then a DONE cycle sets valid.
    always_ff @(posedge s_ctrlport_clk or negedge s_ctrlport_rst_n) begin
        if (!s_ctrlport_rst_n) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else if (w_restart) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    r_sum <= r_sum + w_words[r_idx];
                    if (r_idx == IW'(TOTAL-1)) r_state <= S_DONE;
                    else r_idx <= r_idx + 1'b1;
                end
                S_DONE: begin
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ctrlport.resp_ack    = r_ack;
    assign s_ctrlport.resp_status = r_sts;
    assign s_ctrlport.resp_data   = r_dat;
    assign checksum_valid         = r_valid;
endmodule

// File: tb/tb_x4xx_versioning_regs_ext.sv
// Directed + randomized bench for the versioning register block.
module tb_x4xx_versioning_regs_ext;
    localparam int N    = 4;
    localparam int VW   = 3;
    localparam int RL   = 2;
    localparam int BASE = 'h1000;
    localparam int SB   = N * 16;
    localparam int TOT  = N * VW;
    localparam logic [19:0] A_STATUS = 20'(BASE + SB);
    localparam logic [19:0] A_CSUM   = 20'(BASE + SB + 4);
    localparam logic [19:0] A_ERR    = 20'(BASE + SB + 8);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N*VW*32-1:0]  vinfo;
    logic                cvalid;
    int                  cyc = 0;
    int                  n_cmp = 0;
    int                  n_err = 0;

    // reference model state
    logic [31:0] words [TOT];
    int          m_rc;
    logic [15:0] m_err;

    x4xx_versioning_regs_ext_if bus ();

    x4xx_versioning_regs_ext #(
        .REG_BASE(BASE), .NUM_COMPONENTS(N), .VERSION_WORDS(VW), .READ_LATENCY(RL)
    ) dut (
        .s_ctrlport_clk  (clk),
        .s_ctrlport_rst_n(rst_n),
        .s_ctrlport      (bus),
        .version_info    (vinfo),
        .checksum_valid  (cvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sum of the words scanned before sampling edge s.
    function automatic logic [31:0] partial(input int s);
        int k;
        logic [31:0] acc;
        k = s - 1 - m_rc;
        if (k < 0) k = 0;
        if (k > TOT) k = TOT;
        acc = '0;
        for (int i = 0; i < k; i++) acc = acc + words[i];
        return acc;
    endfunction

    function automatic void model_resp(input bit wr, input logic [19:0] a, input int s,
                                       output bit acked, output logic [1:0] st,
                                       output logic [31:0] dat);
        int off, comp, w;
        off   = int'(a) - BASE;
        acked = (off >= 0) && (off < SB + 16);
        st    = 2'b00;
        dat   = '0;
        if (acked) begin
            comp = off / 16;
            w    = (off % 16) / 4;
            if (comp < N) begin
                if (!wr && w < VW) dat = words[comp*VW + w];
                else st = 2'b01;
            end else begin
                case (w)
                    0: if (!wr) dat = {(s - 1 >= m_rc + TOT + 1), 24'd0, 7'(N)};
                    1: if (wr) st = 2'b01; else dat = partial(s);
                    2: if (!wr) dat = {16'd0, m_err};
                    default: st = 2'b01;
                endcase
            end
        end
    endfunction

    function automatic void model_update(input bit wr, input logic [19:0] a, input logic [31:0] d,
                                         input int s, input bit acked, input logic [1:0] st);
        int off;
        off = int'(a) - BASE;
        if (acked && st == 2'b01 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        if (acked && wr && off >= SB) begin
            if ((off - SB) / 4 == 2) m_err = '0;
            if ((off - SB) / 4 == 0 && d[0]) m_rc = s;
        end
    endfunction

    task automatic xact(input string tag, input bit wr, input bit rd,
                        input logic [19:0] a, input logic [31:0] d);
        bit eack;
        logic [1:0] est, gst;
        logic [31:0] edat, gdat;
        int s, lat, nack;
        @(negedge clk);
        s = cyc + 1;
        model_resp(wr, a, s, eack, est, edat);
        bus.req_wr = wr; bus.req_rd = rd; bus.req_addr = a; bus.req_data = d;
        lat = 0; nack = 0; gst = '0; gdat = '0;
        for (int i = 1; i <= RL + 2; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.req_wr = 1'b0; bus.req_rd = 1'b0; end
            if (bus.resp_ack === 1'b1) begin
                nack++; lat = i; gst = bus.resp_status; gdat = bus.resp_data;
            end
        end
        check({tag, "_acks"}, 32'(nack), eack ? 32'd1 : 32'd0);
        if (eack) begin
            check({tag, "_lat"}, 32'(lat), 32'(RL));
            check({tag, "_sts"}, 32'(gst), 32'(est));
            check({tag, "_dat"}, gdat, edat);
        end
        model_update(wr, a, d, s, eack, est);
    endtask

    task automatic wait_valid(input string tag);
        int guard;
        guard = 0;
        while (cyc < m_rc + TOT && guard < 1000) begin @(negedge clk); guard++; end
        check({tag, "_valid_pre"}, 32'(cvalid), 32'd0);
        @(negedge clk);
        check({tag, "_valid_post"}, 32'(cvalid), 32'd1);
    endtask

    task automatic burst(input int k, input int rst_at, output int nack);
        nack = 0;
        for (int i = 0; i < k + RL + 2; i++) begin
            @(negedge clk);
            if (bus.resp_ack === 1'b1) nack++;
            if (i == rst_at) rst_n = 1'b0;
            bus.req_wr = (i < k); bus.req_rd = 1'b0;
            bus.req_addr = A_CSUM; bus.req_data = $urandom;
        end
        bus.req_wr = 1'b0;
    endtask

    initial begin
        logic [31:0] got [$];
        int when [$];
        int nack, okcnt;
        logic [19:0] ra;
        bit rwr;

        bus.req_wr = 1'b0; bus.req_rd = 1'b0; bus.req_addr = '0; bus.req_data = '0;
        for (int k = 0; k < TOT; k++) begin
            words[k] = $urandom;
            vinfo[k*32 +: 32] = words[k];
        end
        m_err = '0;
        m_rc  = 0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.resp_ack), 32'd0);
        check("rst_sts", 32'(bus.resp_status), 32'd0);
        check("rst_dat", bus.resp_data, 32'd0);
        check("rst_valid", 32'(cvalid), 32'd0);

        rst_n = 1'b1;
        m_rc = cyc;
        wait_valid("scan0");
        xact("csum_full", 1'b0, 1'b1, A_CSUM, '0);
        xact("status_rd", 1'b0, 1'b1, A_STATUS, '0);

        xact("rd_1014", 1'b0, 1'b1, 20'h01014, '0);
        xact("rd_100c_rsv", 1'b0, 1'b1, 20'h0100C, '0);
        xact("errcnt_one", 1'b0, 1'b1, A_ERR, '0);
        check("hold_ack", 32'(bus.resp_ack), 32'd0);
        check("hold_dat", bus.resp_data, {16'd0, m_err});

        // three back-to-back reads, one per cycle
        @(negedge clk);
        bus.req_rd = 1'b1; bus.req_addr = 20'h01000;
        okcnt = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.resp_ack === 1'b1) begin
                got.push_back(bus.resp_data); when.push_back(i);
                if (bus.resp_status === 2'b00) okcnt++;
            end
            if (i == 1) bus.req_addr = 20'h01004;
            if (i == 2) bus.req_addr = 20'h01008;
            if (i == 3) bus.req_rd = 1'b0;
        end
        check("b2b_count", 32'(got.size()), 32'd3);
        check("b2b_ok", 32'(okcnt), 32'd3);
        if (got.size() == 3) begin
            check("b2b_first_lat", 32'(when[0]), 32'(RL));
            check("b2b_last_lat", 32'(when[2]), 32'(RL + 2));
            for (int i = 0; i < 3; i++) check("b2b_dat", got[i], words[i]);
        end

        xact("rd_0ffc_oor", 1'b0, 1'b1, 20'h00FFC, '0);
        xact("rd_1050_oor", 1'b0, 1'b1, 20'h01050, '0);
        xact("wr_1000_ro", 1'b1, 1'b0, 20'h01000, $urandom);
        xact("wr_1048_clr", 1'b1, 1'b0, A_ERR, $urandom);
        xact("errcnt_zero", 1'b0, 1'b1, A_ERR, '0);
        xact("wr_wins", 1'b1, 1'b1, 20'h01014, $urandom);
        xact("errcnt_wr_wins", 1'b0, 1'b1, A_ERR, '0);

        // CMDERR ack and clear land on the same edge: clear wins
        @(negedge clk);
        bus.req_wr = 1'b1; bus.req_addr = A_CSUM;
        @(negedge clk);
        bus.req_addr = A_ERR;
        @(negedge clk);
        bus.req_wr = 1'b0;
        repeat (3) @(negedge clk);
        m_err = '0;
        xact("errcnt_tie", 1'b0, 1'b1, A_ERR, '0);

        // restart, then restart again mid-scan
        xact("restart1", 1'b1, 1'b0, A_STATUS, 32'h1);
        check("restart_valid_clr", 32'(cvalid), 32'd0);
        xact("restart2", 1'b1, 1'b0, A_STATUS, 32'h1);
        xact("csum_partial", 1'b0, 1'b1, A_CSUM, '0);
        wait_valid("rescan");
        xact("csum_rescan", 1'b0, 1'b1, A_CSUM, '0);

        // randomized traffic with no restarts
        for (int t = 0; t < 40; t++) begin
            ra  = 20'(BASE - 16 + 4 * $urandom_range(0, (SB + 48) / 4 - 1));
            rwr = ($urandom_range(0, 2) == 0);
            xact("rand", rwr, !rwr || ($urandom_range(0, 1) == 1), ra, $urandom & 32'hFFFF_FFFE);
        end

        // saturation
        burst(65600, -1, nack);
        check("sat_acks", 32'(nack), 32'd65600);
        m_err = ((int'(m_err) + nack) > 'hFFFF) ? 16'hFFFF : 16'(int'(m_err) + nack);
        xact("errcnt_sat", 1'b0, 1'b1, A_ERR, '0);

        // reset pulse in the middle of a burst
        burst(20, 10, nack);
        check("rstmid_ack", 32'(bus.resp_ack), 32'd0);
        check("rstmid_sts", 32'(bus.resp_status), 32'd0);
        check("rstmid_dat", bus.resp_data, 32'd0);
        check("rstmid_valid", 32'(cvalid), 32'd0);
        rst_n = 1'b1;
        m_rc  = cyc;
        m_err = '0;
        nack  = 0;
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk);
            if (bus.resp_ack === 1'b1) nack++;
        end
        check("rstmid_no_ack", 32'(nack), 32'd0);
        xact("rstmid_errcnt", 1'b0, 1'b1, A_ERR, '0);
        wait_valid("rstmid_scan");
        xact("rstmid_csum", 1'b0, 1'b1, A_CSUM, '0);
        xact("rstmid_status", 1'b0, 1'b1, A_STATUS, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
